// File: rtl/verinject_pkg.sv
// verinject_pkg: shared widths, player state and schedule entry type for the sched player
package verinject_pkg;
  localparam int CYC_W_DEF = 48;
  localparam int STATE_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} player_state_e;
  typedef struct packed {
    logic [CYC_W_DEF-1:0]   cycle;
    logic [STATE_W_DEF-1:0] target;
  } sched_entry_t;
endpackage

// File: rtl/verinject_sched_fifo.sv
// verinject_sched_fifo: DEPTH-entry synchronous show-ahead FIFO of packed schedule entries
// Ports: clock, reset_n (sync, active-low), push_i/data_i write side,
//        pop_i/head_o read side (head valid while !empty_o), count_o occupancy, empty_o.
module verinject_sched_fifo
  import verinject_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W = CYC_W_DEF + STATE_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;
  assign push_ok = push_i && cnt_q != CW'(DEPTH);
  assign pop_ok  = pop_i && cnt_q != '0;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= push_ok ? wr_q + 1'b1 : wr_q;
      rd_q  <= pop_ok ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end
  always_ff @(posedge clock)
    if (push_ok) mem_q[wr_q] <= data_i;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/verinject_sched_player.sv
// verinject_sched_player: cycle-scheduled fault-injection driver feeding verinject__injector_state
// Ports: clock, reset_n (sync, active-low); sched_valid/sched_ready/sched_cycle/sched_target push
//        side; start arms playback; verinject__injector_state one-cycle injection command;
//        cycle_number saturating cycle count; busy, done, late_err (sticky missed-entry flag).
// Build option: define VERINJECT_TRACE_EN for a simulation $display on every fire and late drop.
module verinject_sched_player #(
  parameter int DEPTH   = 16,
  parameter int STATE_W = verinject_pkg::STATE_W_DEF,
  parameter int CYC_W   = verinject_pkg::CYC_W_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sched_valid,
  output logic               sched_ready,
  input  logic [CYC_W-1:0]   sched_cycle,
  input  logic [STATE_W-1:0] sched_target,
  input  logic               start,
  output logic [STATE_W-1:0] verinject__injector_state,
  output logic [CYC_W-1:0]   cycle_number,
  output logic               busy,
  output logic               done,
  output logic               late_err
);
  import verinject_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [CYC_W-1:0]   cycle;
    logic [STATE_W-1:0] target;
  } entry_t;
  player_state_e      state_q, state_d;
  entry_t             head, wr_entry;
  logic [CYC_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] inj_q, inj_d;
  logic [CW-1:0]      count, count_d;
  logic               late_q, late_d, ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic               push, pop, fire, miss, empty;
  assign push     = sched_valid && ready_q;
  assign wr_entry = '{cycle: sched_cycle, target: sched_target};
  verinject_sched_fifo #(.DEPTH(DEPTH), .W(CYC_W + STATE_W)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (push),
    .data_i  (wr_entry),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );
  // The head is judged against the value the counter takes on the next edge, so a
  // registered fire lines up with cycle_number == sched_cycle.
  always_comb begin
    cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
    fire    = state_q == RUN && !empty && head.cycle == cnt_d;
    miss    = state_q == RUN && !empty && head.cycle < cnt_d;
    pop     = fire || miss;
    inj_d   = fire ? head.target : '0;
    late_d  = late_q || miss;
    count_d = count + CW'(push) - CW'(pop);
    state_d = (state_q == IDLE && start) ? RUN :
              (state_q == RUN && empty && !push) ? DONE : state_q;
    ready_d = count_d != CW'(DEPTH) && state_d != DONE;
    busy_d  = state_d == RUN && count_d != '0;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      inj_q   <= '0;
      late_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inj_q   <= inj_d;
      late_q  <= late_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
`ifdef VERINJECT_TRACE_EN
  always_ff @(posedge clock) begin
    if (reset_n && fire) $display("inject t=%0d target=%h", cnt_d, head.target);
    if (reset_n && miss) $display("late drop t=%0d cycle=%0d target=%h", cnt_d, head.cycle, head.target);
  end
`endif
  assign sched_ready               = ready_q;
  assign verinject__injector_state = inj_q;
  assign cycle_number              = cnt_q;
  assign busy                      = busy_q;
  assign done                      = done_q;
  assign late_err                  = late_q;
endmodule
